// File: rtl/instr_issue_unit.sv
// Instruction issue unit: FIFO-buffered instruction register feeding the control FSM, owns current_state.
// Latency: push to earliest IR load 1 cycle; IR load to done = FSM steps + 1 cycles.
// Backpressure: instr_ready = !full (a same-cycle pop does not free a slot); optional RETIRE_COUNT_EN adds counters.
module instr_issue_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STEPS  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  next_state,
  output logic [4:0]  current_state,
  output logic [3:0]  func,
  output logic [2:0]  input1,
  output logic [2:0]  input2,
  output logic [7:0]  imm_data,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        abort
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0] retired_cnt,
  output logic [7:0]  fault_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT  = FIFO_DEPTH[PW:0];
  localparam logic [3:0]  MAX_STEP_C = MAX_STEPS[3:0];

  typedef enum logic {IDLE, EXEC} ctrl_t;

  ctrl_t        ctrl_q, ctrl_d;
  logic [17:0]  ir_q, ir_d;
  logic [4:0]   cur_state_q, cur_state_d;
  logic [3:0]   step_cnt_q, step_cnt_d;
  logic         done_q, done_d;
  logic         illegal_q, illegal_d;
  logic         abort_q, abort_d;
  logic [17:0]  mem_q [FIFO_DEPTH];
  logic [17:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]  count_q, count_d;
  logic         push, pop, fifo_empty, retire;
  logic [17:0]  fifo_head;
`ifdef RETIRE_COUNT_EN
  logic [15:0]  retired_cnt_q, retired_cnt_d;
  logic [7:0]   fault_cnt_q, fault_cnt_d;
`endif

  assign fifo_empty  = (count_q == '0);
  assign fifo_head   = mem_q[rd_ptr_q];
  assign instr_ready = (count_q != FULL_CNT);

  // Outputs are gated flops, so they stay stable for the whole instruction and drop to NOP outside EXEC.
  always_comb begin
    busy          = (ctrl_q == EXEC);
    func          = busy ? ir_q[17:14] : 4'b0000;
    input1        = busy ? ir_q[13:11] : 3'd0;
    input2        = busy ? ir_q[10:8]  : 3'd0;
    imm_data      = busy ? ir_q[7:0]   : 8'd0;
    current_state = cur_state_q;
    done          = done_q;
    illegal       = illegal_q;
    abort         = abort_q;
  end

  // Control FSM, retire detection and FIFO bookkeeping.
  always_comb begin
    push        = instr_valid && instr_ready;
    pop         = 1'b0;
    retire      = 1'b0;
    ctrl_d      = ctrl_q;
    ir_d        = ir_q;
    cur_state_d = cur_state_q;
    step_cnt_d  = step_cnt_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    abort_d     = 1'b0;
    case (ctrl_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          ir_d        = fifo_head;
          cur_state_d = 5'd0;
          step_cnt_d  = 4'd0;
          ctrl_d      = EXEC;
        end
      end
      default: begin
        if (next_state == 5'd0) begin
          // Returning to 0 retires; never leaving 0 means the opcode had no step.
          retire    = 1'b1;
          illegal_d = (cur_state_q == 5'd0);
        end else if (step_cnt_q == MAX_STEP_C) begin
          retire  = 1'b1;
          abort_d = 1'b1;
        end else begin
          cur_state_d = next_state;
          step_cnt_d  = step_cnt_q + 4'd1;
        end
        if (retire) begin
          done_d      = 1'b1;
          cur_state_d = 5'd0;
          step_cnt_d  = 4'd0;
          if (!fifo_empty) begin
            pop  = 1'b1;
            ir_d = fifo_head;
          end else begin
            ctrl_d = IDLE;
          end
        end
      end
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = instr_in;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

`ifdef RETIRE_COUNT_EN
    retired_cnt_d = done_d ? retired_cnt_q + 16'd1 : retired_cnt_q;
    fault_cnt_d   = (illegal_d || abort_d) ? fault_cnt_q + 8'd1 : fault_cnt_q;
`endif
  end

  // State registers; reset flushes the FIFO and drops any executing instruction without retiring it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= IDLE;
      ir_q        <= '0;
      cur_state_q <= '0;
      step_cnt_q  <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      abort_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef RETIRE_COUNT_EN
      retired_cnt_q <= '0;
      fault_cnt_q   <= '0;
`endif
    end else begin
      ctrl_q      <= ctrl_d;
      ir_q        <= ir_d;
      cur_state_q <= cur_state_d;
      step_cnt_q  <= step_cnt_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      abort_q     <= abort_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef RETIRE_COUNT_EN
      retired_cnt_q <= retired_cnt_d;
      fault_cnt_q   <= fault_cnt_d;
`endif
    end
  end

`ifdef RETIRE_COUNT_EN
  assign retired_cnt = retired_cnt_q;
  assign fault_cnt   = fault_cnt_q;
`endif

endmodule
